// File: rtl/cache_2way_wb_pkg.sv
// cache_2way_wb_pkg: shared FSM state type and address-field width helpers for the 2-way write-back cache.
package cache_2way_wb_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    // Word address layout is {tag, index, offset}, offset in the low bits.
    function automatic int off_w(int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int addr_w, int words, int sets);
        return addr_w - $clog2(words) - $clog2(sets);
    endfunction
endpackage

// File: rtl/cache_2way_wb_if.sv
// cache_2way_wb_if: processor-side and memory-side bus interfaces of the 2-way write-back cache.
interface cache_2way_wb_proc_if #(parameter int ADDR_W = 30, parameter int DATA_W = 32);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_stall;
    logic [DATA_W-1:0] proc_rdata;
    modport master (output proc_read, proc_write, proc_addr, proc_wdata, input proc_stall, proc_rdata);
    modport slave (input proc_read, proc_write, proc_addr, proc_wdata, output proc_stall, proc_rdata);
endinterface

interface cache_2way_wb_mem_if import cache_2way_wb_pkg::*; #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
);
    localparam int BLK_W  = ADDR_W - off_w(WORDS);
    localparam int LINE_W = WORDS * DATA_W;
    logic              mem_read;
    logic              mem_write;
    logic [BLK_W-1:0]  mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cache_2way_wb_victim_buf.sv
// cache_2way_wb_victim_buf: one-entry dirty-victim buffer and memory-port sequencer; fills win over drains.
module cache_2way_wb_victim_buf #(
    parameter int BLK_W  = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              fill_start,
    input  logic [BLK_W-1:0]  blk_addr,
    input  logic              buf_load,
    input  logic [BLK_W-1:0]  load_addr,
    input  logic [LINE_W-1:0] load_data,
    output logic              busy,
    output logic              buf_valid,
    output logic              addr_match,
    output logic              fill_done,
    cache_2way_wb_mem_if.master mem
);
    logic [BLK_W-1:0]  buf_addr;
    logic [LINE_W-1:0] buf_data;

    assign busy       = mem.mem_read || mem.mem_write;
    assign fill_done  = mem.mem_read && mem.mem_ready;
    assign addr_match = buf_valid && buf_addr == blk_addr;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            buf_valid     <= 1'b0;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if (busy) begin
                if (mem.mem_ready) begin
                    mem.mem_read  <= 1'b0;
                    mem.mem_write <= 1'b0;
                end
            end else if (fill_start) begin
                mem.mem_read <= 1'b1;
                mem.mem_addr <= blk_addr;
            end else if (buf_valid) begin
                mem.mem_write <= 1'b1;
                mem.mem_addr  <= buf_addr;
                mem.mem_wdata <= buf_data;
            end
            // A load only happens with the buffer empty, so it never races a drain completion.
            if (buf_load) buf_valid <= 1'b1;
            else if (mem.mem_write && mem.mem_ready) buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_addr <= load_addr;
            buf_data <= load_data;
        end
    end
endmodule

// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative write-back, write-allocate cache with 1-bit LRU and a victim buffer.
module cache_2way_wb import cache_2way_wb_pkg::*; #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 4
) (
    input  logic clk,
    input  logic proc_reset,
    cache_2way_wb_proc_if.slave proc,
    cache_2way_wb_mem_if.master mem
);
    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS);
    localparam int BLK_W  = ADDR_W - OFF_W;
    localparam int LINE_W = WORDS * DATA_W;

    state_t            state;
    logic [TAG_W-1:0]  tag_arr  [2][SETS];
    logic [LINE_W-1:0] data_arr [2][SETS];
    logic [1:0]        valid    [SETS];
    logic [1:0]        dirty    [SETS];
    logic [SETS-1:0]   lru;
    logic              fill_way;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [BLK_W-1:0]  blk;
    logic [1:0]        hit_w;
    logic              hit, hit_way, req, miss, we, vic, vic_dirty, can_fill, launch;
    logic              busy, buf_valid, addr_match, fill_done;

    assign tag     = proc.proc_addr[ADDR_W-1 -: TAG_W];
    assign idx     = proc.proc_addr[OFF_W +: IDX_W];
    assign off     = proc.proc_addr[OFF_W-1:0];
    assign blk     = proc.proc_addr[ADDR_W-1:OFF_W];
    assign hit_w   = {valid[idx][1] && tag_arr[1][idx] == tag, valid[idx][0] && tag_arr[0][idx] == tag};
    assign hit     = |hit_w;
    assign hit_way = hit_w[1];
    assign req     = proc.proc_read || proc.proc_write;
    assign miss    = req && !hit;
    assign we      = proc.proc_write && !proc.proc_read && hit;

    // LRU bit names the way to evict next; invalid ways are always taken first.
    assign vic       = !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
    assign vic_dirty = valid[idx][vic] && dirty[idx][vic];
    // A buffered block matching the miss must reach memory before it is re-read.
    assign can_fill  = !busy && !(vic_dirty && buf_valid) && !addr_match;
    assign launch    = miss && state != FILL && can_fill;

    assign proc.proc_stall = !proc_reset && miss;
    assign proc.proc_rdata = (proc.proc_read && hit) ? data_arr[hit_way][idx][off*DATA_W +: DATA_W] : '0;

    cache_2way_wb_victim_buf #(.BLK_W(BLK_W), .LINE_W(LINE_W)) u_vbuf (
        .clk        (clk),
        .proc_reset (proc_reset),
        .fill_start (launch),
        .blk_addr   (blk),
        .buf_load   (launch && vic_dirty),
        .load_addr  ({tag_arr[vic][idx], idx}),
        .load_data  (data_arr[vic][idx]),
        .busy       (busy),
        .buf_valid  (buf_valid),
        .addr_match (addr_match),
        .fill_done  (fill_done),
        .mem        (mem)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state    <= IDLE;
            valid    <= '{default: '0};
            dirty    <= '{default: '0};
            lru      <= '0;
            fill_way <= 1'b0;
        end else begin
            if (state == FILL) begin
                if (fill_done) begin
                    state                <= IDLE;
                    valid[idx][fill_way] <= 1'b1;
                    dirty[idx][fill_way] <= 1'b0;
                end
            end else begin
                state <= launch ? FILL : miss ? DRAIN : IDLE;
                if (launch) fill_way <= vic;
            end
            if (hit) lru[idx] <= !hit_way;
            if (we) dirty[idx][hit_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && fill_done) begin
            data_arr[fill_way][idx] <= mem.mem_rdata;
            tag_arr[fill_way][idx]  <= tag;
        end
        if (we) data_arr[hit_way][idx][off*DATA_W +: DATA_W] <= proc.proc_wdata;
    end
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: directed vector table plus hand-written eviction, drain and reset sequences.
module tb_cache_2way_wb;
    localparam int LAT = 3;

    typedef struct {
        logic        rd;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    logic clk;
    logic proc_reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    logic [28:0]  evq[$];
    logic [127:0] store [logic [27:0]];
    vec_t vecs [10];

    cache_2way_wb_proc_if #(.ADDR_W(30), .DATA_W(32)) pif ();
    cache_2way_wb_mem_if #(.ADDR_W(30), .DATA_W(32), .WORDS(4)) mif ();

    cache_2way_wb #(.ADDR_W(30), .DATA_W(32), .WORDS(4), .SETS(4)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc       (pif.slave),
        .mem        (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(logic [29:0] a);
        return {2'b00, a} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] rd_blk(logic [27:0] b);
        logic [127:0] r;
        if (store.exists(b)) return store[b];
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = dflt({b, k[1:0]});
        return r;
    endfunction

    // Memory model: ready LAT negedges after a request first appears, one cycle wide.
    initial begin
        int cnt;
        cnt = 0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mif.mem_ready) mif.mem_ready = 1'b0;
            else if (mif.mem_read || mif.mem_write) begin
                if (cnt == 0) begin
                    evq.push_back({mif.mem_write, mif.mem_addr});
                    if (mif.mem_write) n_wr++;
                    else n_rd++;
                end
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    mif.mem_ready = 1'b1;
                    if (mif.mem_write) store[mif.mem_addr] = mif.mem_wdata;
                    else mif.mem_rdata = rd_blk(mif.mem_addr);
                end
            end else cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic rd, input logic [29:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int stalls);
        @(negedge clk);
        pif.proc_read  = rd;
        pif.proc_write = !rd;
        pif.proc_addr  = a;
        pif.proc_wdata = d;
        #1;
        stalls = 0;
        while (pif.proc_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (pif.proc_stall) begin
            n_chk++;
            n_fail++;
            $display("FAIL stall timeout at addr %0h: stall still high, required low", a);
        end
        rdata = pif.proc_rdata;
        @(posedge clk);
        #1;
        pif.proc_read  = 1'b0;
        pif.proc_write = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int st;
        vecs[0] = '{1'b1, 30'h000, 32'h0,        dflt(30'h000), 4, 1, 0};
        vecs[1] = '{1'b1, 30'h000, 32'h0,        dflt(30'h000), 0, 1, 0};
        vecs[2] = '{1'b1, 30'h004, 32'h0,        dflt(30'h004), 4, 2, 0};
        vecs[3] = '{1'b0, 30'h006, 32'hDEADBEEF, 32'h0,         0, 2, 0};
        vecs[4] = '{1'b1, 30'h006, 32'h0,        32'hDEADBEEF,  0, 2, 0};
        vecs[5] = '{1'b0, 30'h010, 32'h11,       32'h0,         4, 3, 0};
        vecs[6] = '{1'b0, 30'h020, 32'h22,       32'h0,         4, 4, 0};
        vecs[7] = '{1'b1, 30'h010, 32'h0,        32'h11,        0, 4, 0};
        vecs[8] = '{1'b1, 30'h013, 32'h0,        dflt(30'h013), 0, 4, 0};
        vecs[9] = '{1'b1, 30'h020, 32'h0,        32'h22,        0, 4, 0};

        proc_reset     = 1'b1;
        pif.proc_read  = 1'b1;
        pif.proc_write = 1'b0;
        pif.proc_addr  = '0;
        pif.proc_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", pif.proc_stall, 0);
        chk("reset rdata", pif.proc_rdata, 0);
        chk("reset mem_read", mif.mem_read, 0);
        chk("reset mem_write", mif.mem_write, 0);
        chk("reset mem_addr", mif.mem_addr, 0);
        chk("reset mem_wdata", mif.mem_wdata, 0);
        pif.proc_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].addr, vecs[i].wdata, got, st);
            if (vecs[i].rd) chk($sformatf("vec%0d rdata", i), got, vecs[i].exp_rdata);
            chk($sformatf("vec%0d stalls", i), st, vecs[i].exp_stalls);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d mem reads", i), n_rd, vecs[i].exp_nrd);
            chk($sformatf("vec%0d mem writes", i), n_wr, vecs[i].exp_nwr);
        end

        // Set 0 holds dirty B (way0) and dirty A (way1), LRU names A: miss on C evicts A.
        access(1'b1, 30'h030, 32'h0, got, st);
        chk("missC rdata", got, dflt(30'h030));
        chk("missC stalls", st, 4);
        chk("drainA mem_write", mif.mem_write, 1);
        chk("drainA mem_read", mif.mem_read, 0);
        chk("drainA mem_addr", mif.mem_addr, 28'h4);
        chk("drainA word0", mif.mem_wdata[31:0], 32'h11);
        access(1'b1, 30'h004, 32'h0, got, st);
        chk("hit during drain rdata", got, dflt(30'h004));
        chk("hit during drain stalls", st, 0);
        chk("drain still active", mif.mem_write, 1);
        // Miss on D needs B evicted while A is still in the buffer.
        access(1'b1, 30'h040, 32'h0, got, st);
        chk("missD rdata", got, dflt(30'h040));
        chk("missD stalls", st, 6);
        // B just went to the buffer; re-reading it waits for its drain.
        access(1'b1, 30'h020, 32'h0, got, st);
        chk("reread B rdata", got, 32'h22);
        chk("reread B stalls", st, 7);
        chk("event count", evq.size(), 9);
        chk("ev4 read C", evq[4], {1'b0, 28'hC});
        chk("ev5 write A", evq[5], {1'b1, 28'h4});
        chk("ev6 read D", evq[6], {1'b0, 28'h10});
        chk("ev7 write B", evq[7], {1'b1, 28'h8});
        chk("ev8 read B", evq[8], {1'b0, 28'h8});
        chk("mem A word0", store[28'h4][31:0], 32'h11);
        chk("mem A word1", store[28'h4][63:32], dflt(30'h011));

        // Reset in the middle of a fill.
        @(negedge clk);
        pif.proc_read = 1'b1;
        pif.proc_addr = 30'h000;
        @(posedge clk);
        #1;
        chk("fill issued", mif.mem_read, 1);
        chk("fill addr", mif.mem_addr, 28'h0);
        @(negedge clk);
        #2;
        proc_reset = 1'b1;
        #1;
        chk("async reset mem_read", mif.mem_read, 0);
        chk("async reset mem_write", mif.mem_write, 0);
        chk("async reset mem_addr", mif.mem_addr, 0);
        chk("async reset mem_wdata", mif.mem_wdata, 0);
        chk("async reset stall", pif.proc_stall, 0);
        chk("async reset rdata", pif.proc_rdata, 0);
        @(negedge clk);
        pif.proc_read = 1'b0;
        proc_reset = 1'b0;
        access(1'b1, 30'h000, 32'h0, got, st);
        chk("post-reset miss rdata", got, dflt(30'h000));
        chk("post-reset miss stalls", st, 4);
        access(1'b1, 30'h020, 32'h0, got, st);
        chk("post-reset B rdata", got, 32'h22);
        chk("post-reset B stalls", st, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
